// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative RV32M multiply/divide unit.
// master = pipeline side, slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct3, operand_a, operand_b,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct3, operand_a, operand_b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Divide-by-zero and signed overflow finish in one cycle without entering CALC.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_next;
  logic [2:0]        fn;
  logic [XLEN-1:0]   a_mag, b_mag, result_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic              neg_q, neg_r;
  logic [CNT_W-1:0]  counter;

  logic              accept, calc_last, fast;
  logic              a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   a_abs, b_abs, fast_result;
  logic [XLEN:0]     sum, shifted, diff, rem_next;
  logic              borrow, ge;
  logic [2*XLEN-1:0] acc_next, prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, final_result;

  // Operand decode for the accept cycle
  always_comb begin
    a_signed    = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_signed    = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
    sa          = a_signed & bus.operand_a[XLEN-1];
    sb          = b_signed & bus.operand_b[XLEN-1];
    a_abs       = sa ? ('0 - bus.operand_a) : bus.operand_a;
    b_abs       = sb ? ('0 - bus.operand_b) : bus.operand_b;
    div_zero    = (bus.operand_b == '0);
    div_ovf     = ~bus.funct3[0] & (bus.operand_a == INT_MIN) & (bus.operand_b == '1);
    fast        = bus.funct3[2] & (div_zero | div_ovf);
    if (div_zero)
      fast_result = bus.funct3[1] ? bus.operand_a : '1;
    else
      fast_result = bus.funct3[1] ? '0 : INT_MIN;
    accept      = bus.start & ~bus.flush & ((state == IDLE) | (state == DONE));
    calc_last   = (counter == CNT_W'(XLEN-1));
  end

  // One iteration step plus sign fix-up of the would-be final value
  always_comb begin
    sum            = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
    shifted        = {rem[XLEN-1:0], acc[XLEN-1]};
    {borrow, diff} = {1'b0, shifted} - {2'b0, b_mag};
    // rem[XLEN] set means the true shifted value already exceeds any divisor
    ge             = rem[XLEN] | ~borrow;
    rem_next       = ge ? diff : shifted;
    if (fn[2])
      acc_next = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ge};
    else
      acc_next = {sum, acc[XLEN-1:1]};
    prod_fix = neg_q ? ('0 - acc_next) : acc_next;
    q_fix    = neg_q ? ('0 - acc_next[XLEN-1:0]) : acc_next[XLEN-1:0];
    r_fix    = neg_r ? ('0 - rem_next[XLEN-1:0]) : rem_next[XLEN-1:0];
    case (fn)
      3'b000:                 final_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_result = q_fix;
      default:                final_result = r_fix;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = accept ? (fast ? DONE : CALC) : IDLE;
      CALC:       if (calc_last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
    if (bus.flush) state_next = IDLE;
  end

  assign bus.busy   = (state == CALC);
  assign bus.done   = (state == DONE) & ~bus.flush;
  assign bus.result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fn       <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      counter  <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        fn      <= bus.funct3;
        a_mag   <= a_abs;
        b_mag   <= b_abs;
        neg_q   <= sa ^ sb;
        neg_r   <= sa;
        counter <= '0;
        acc     <= {{XLEN{1'b0}}, (bus.funct3[2] ? a_abs : b_abs)};
        rem     <= '0;
        if (fast) result_q <= fast_result;
      end else if (state == CALC && !bus.flush) begin
        acc     <= acc_next;
        rem     <= rem_next;
        counter <= counter + 1'b1;
        if (calc_last) result_q <= final_result;
      end
    end
  end
endmodule
